// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between an 8-bit CPU
// and a 32-bit block memory; stalls the CPU via BUSYWAIT on a miss.
module dcache_controller #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int TAG_BITS   = 6 - INDEX_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FETCH,
    S_UPDATE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]           data_q [NUM_BLOCKS];
  logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  logic        mem_read_q, mem_write_q;
  logic [5:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   req;
  logic                   hit;
  logic                   write_hit;
  logic [31:0]            cur_block;

  assign req_tag   = ADDRESS[7 -: TAG_BITS];
  assign req_idx   = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign req_off   = ADDRESS[OFFSET_BITS-1:0];
  assign req       = READ | WRITE;
  assign cur_block = data_q[req_idx];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A simultaneous READ and WRITE is handled as a write; reads never modify state.
  assign write_hit = WRITE && (state_q == S_IDLE) && hit;

  assign BUSYWAIT = req && !((state_q == S_IDLE) && hit);

  // Gating by valid makes the load port read zero out of reset without
  // having to clear the data array.
  assign READDATA = valid_q[req_idx] ? cur_block[{req_off, 3'b000} +: 8] : 8'h00;

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d     = S_WRITEBACK;
            mem_addr_d  = {tag_q[req_idx], req_idx};
            mem_wdata_d = cur_block;
          end else begin
            state_d    = S_FETCH;
            mem_addr_d = {req_tag, req_idx};
          end
        end
      end
      S_WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_d    = S_FETCH;
          mem_addr_d = {req_tag, req_idx};
        end
      end
      S_FETCH: begin
        if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes, address and write data are flops loaded on the state transition,
  // so they are glitch-free and stay stable for the whole memory transaction.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RESET) begin
      state_q     <= S_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= (state_d == S_FETCH);
      mem_write_q <= (state_d == S_WRITEBACK);
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == S_UPDATE) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // NOTE: the data and tag arrays are deliberately not reset; valid bits
  // qualify them, and leaving them reset-free lets them map onto RAM.
  always_ff @(posedge CLK) begin
    if (state_q == S_UPDATE) begin
      data_q[req_idx] <= MEM_READDATA;
      tag_q[req_idx]  <= req_tag;
    end else if (write_hit) begin
      data_q[req_idx][{req_off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed CPU requests against a
// 5-cycle-busy block memory model; a negedge monitor checks every completion.
module tb_dcache_controller;

  localparam int MEM_LAT    = 5;
  // Request cycle in IDLE + each memory phase (busy cycles + completing cycle) + UPDATE.
  localparam int MISS_CLEAN = 1 + (MEM_LAT + 1) + 1;
  localparam int MISS_DIRTY = 1 + 2 * (MEM_LAT + 1) + 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Block memory model: busy for MEM_LAT cycles of a strobe, completes on the next edge.
  logic [31:0] mem [64];
  int          busy_cnt;
  logic [31:0] rdata_q;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (busy_cnt < MEM_LAT);
  assign MEM_READDATA = rdata_q;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h00] = 32'h0F0E0D0C;
    mem[6'h01] = 32'h44332211;
    mem[6'h04] = 32'hDDCCBBAA;
    mem[6'h08] = 32'h1F1E1D1C;
    mem[6'h09] = 32'h88776655;
    mem[6'h0C] = 32'h12345678;
    busy_cnt = 0;
    rdata_q  = 32'h0;
    forever begin
      @(posedge CLK);
      if (MEM_READ || MEM_WRITE) begin
        if (!MEM_BUSYWAIT) begin
          busy_cnt <= 0;
          if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          else           rdata_q <= mem[MEM_ADDRESS];
        end else begin
          busy_cnt <= busy_cnt + 1;
        end
      end else begin
        busy_cnt <= 0;
      end
    end
  end

  typedef struct {
    logic        is_write;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_exp_t;

  typedef struct {
    logic       is_read;
    logic [7:0] data;
    int         stall;
  } req_exp_t;

  mem_exp_t mem_q[$];
  req_exp_t req_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected memory op / request result whenever the DUT completes one.
  initial begin
    int       stall_cnt;
    mem_exp_t m;
    req_exp_t r;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (MEM_READ || MEM_WRITE) begin
          check("strobe_overlap", {31'b0, MEM_READ & MEM_WRITE}, 32'h0);
          if (!MEM_BUSYWAIT) begin
            if (mem_q.size() == 0) begin
              check("unexpected_mem_op", {26'b0, MEM_ADDRESS}, 32'hFFFF_FFFF);
            end else begin
              m = mem_q.pop_front();
              check("mem_op_is_write", {31'b0, MEM_WRITE}, {31'b0, m.is_write});
              check("mem_address", {26'b0, MEM_ADDRESS}, {26'b0, m.addr});
              if (m.is_write) check("mem_writedata", MEM_WRITEDATA, m.data);
            end
          end
        end
        if (READ || WRITE) begin
          if (BUSYWAIT) begin
            stall_cnt++;
          end else begin
            if (req_q.size() == 0) begin
              check("unexpected_completion", {24'b0, ADDRESS}, 32'hFFFF_FFFF);
            end else begin
              r = req_q.pop_front();
              check("stall_cycles", stall_cnt, r.stall);
              if (r.is_read) check("readdata", {24'b0, READDATA}, {24'b0, r.data});
            end
            stall_cnt = 0;
          end
        end else begin
          stall_cnt = 0;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  task automatic expect_mem(input logic is_write, input logic [5:0] addr, input logic [31:0] data);
    mem_exp_t m;
    m.is_write = is_write;
    m.addr     = addr;
    m.data     = data;
    mem_q.push_back(m);
  endtask

  // Issue one request (called just after a posedge) and hold it until BUSYWAIT drops.
  task automatic do_req(input logic rd, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_data, input int exp_stall);
    req_exp_t r;
    bit       done;
    r.is_read = rd;
    r.data    = exp_data;
    r.stall   = exp_stall;
    req_q.push_back(r);
    READ      = rd;
    WRITE     = !rd;
    ADDRESS   = addr;
    WRITEDATA = wd;
    done      = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL req_timeout: addr 0x%0h still stalled after 200 cycles", addr);
    end
    @(posedge CLK);
    #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    bit seen;
    RESET     = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 8'h00;
    WRITEDATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_busywait", {31'b0, BUSYWAIT}, 32'h0);
    check("reset_mem_read", {31'b0, MEM_READ}, 32'h0);
    check("reset_mem_write", {31'b0, MEM_WRITE}, 32'h0);
    check("reset_readdata", {24'b0, READDATA}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Clean miss, then hits in the freshly loaded block.
    expect_mem(1'b0, 6'h01, 32'h0);
    do_req(1'b1, 8'h05, 8'h00, 8'h22, MISS_CLEAN);
    do_req(1'b1, 8'h06, 8'h00, 8'h33, 0);
    do_req(1'b0, 8'h07, 8'hAB, 8'h00, 0);
    do_req(1'b1, 8'h07, 8'h00, 8'hAB, 0);

    // Dirty eviction of block 1 by tag 1, then bring tag 0 back to see the written-back byte.
    expect_mem(1'b1, 6'h01, 32'hAB332211);
    expect_mem(1'b0, 6'h09, 32'h0);
    do_req(1'b1, 8'h27, 8'h00, 8'h88, MISS_DIRTY);
    expect_mem(1'b0, 6'h01, 32'h0);
    do_req(1'b1, 8'h07, 8'h00, 8'hAB, MISS_CLEAN);
    do_req(1'b1, 8'h04, 8'h00, 8'h11, 0);

    // Write-allocate miss into invalid index 4; its dirty bit shows up on eviction.
    expect_mem(1'b0, 6'h04, 32'h0);
    do_req(1'b0, 8'h10, 8'h5A, 8'h00, MISS_CLEAN);
    do_req(1'b1, 8'h10, 8'h00, 8'h5A, 0);
    do_req(1'b1, 8'h11, 8'h00, 8'hBB, 0);
    expect_mem(1'b1, 6'h04, 32'hDDCCBB5A);
    expect_mem(1'b0, 6'h0C, 32'h0);
    do_req(1'b1, 8'h30, 8'h00, 8'h78, MISS_DIRTY);

    // Index wrap: 0x00 and 0x20 share block 0.
    expect_mem(1'b0, 6'h00, 32'h0);
    do_req(1'b1, 8'h00, 8'h00, 8'h0C, MISS_CLEAN);
    expect_mem(1'b0, 6'h08, 32'h0);
    do_req(1'b1, 8'h20, 8'h00, 8'h1C, MISS_CLEAN);
    expect_mem(1'b0, 6'h00, 32'h0);
    do_req(1'b1, 8'h00, 8'h00, 8'h0C, MISS_CLEAN);
    do_req(1'b0, 8'h03, 8'hC3, 8'h00, 0);
    expect_mem(1'b1, 6'h00, 32'hC30E0D0C);
    expect_mem(1'b0, 6'h08, 32'h0);
    do_req(1'b1, 8'h23, 8'h00, 8'h1F, MISS_DIRTY);

    // Reset in the middle of a fetch aborts it; nothing is queued for this request.
    READ    = 1'b1;
    ADDRESS = 8'h25;
    seen    = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (MEM_READ) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_fetch_started", {31'b0, seen}, 32'h1);
    check("abort_fetch_address", {26'b0, MEM_ADDRESS}, 32'h09);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("abort_mem_read_drops", {31'b0, MEM_READ}, 32'h0);
    check("abort_busywait_miss", {31'b0, BUSYWAIT}, 32'h1);
    READ = 1'b0;
    #1;
    check("abort_busywait_idle", {31'b0, BUSYWAIT}, 32'h0);
    check("abort_readdata", {24'b0, READDATA}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    expect_mem(1'b0, 6'h01, 32'h0);
    do_req(1'b1, 8'h05, 8'h00, 8'h22, MISS_CLEAN);
    expect_mem(1'b0, 6'h00, 32'h0);
    do_req(1'b1, 8'h03, 8'h00, 8'hC3, MISS_CLEAN);

    repeat (3) @(posedge CLK);
    #1;
    check("req_queue_drained", req_q.size(), 32'h0);
    check("mem_queue_drained", mem_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
